// File: rtl/mic1_pkg.sv
// Shared definitions for the MIC-1 microsequencer: default widths, stack-operation
// encodings and the combinational next-address function.
package mic1_pkg;

    localparam int unsigned MIC1_ADDR_W = 9;
    localparam int unsigned MIC1_MBR_W  = 8;

    // Stack operation encodings selected by the sequencer each cycle
    localparam logic [1:0] STK_NOP  = 2'd0;
    localparam logic [1:0] STK_PUSH = 2'd1;
    localparam logic [1:0] STK_POP  = 2'd2;

    // Operands are zero-extended to 32 bits by the caller; addr_w selects the JAM bit.
    function automatic logic [31:0] mic1_next_addr(
        input logic [31:0]  next_addr,
        input logic         jmpc,
        input logic         jamn,
        input logic         jamz,
        input logic         n,
        input logic         z,
        input logic [31:0]  mbr,
        input int unsigned  addr_w
    );
        logic [31:0] t;
        t = next_addr;
        if ((jamn & n) | (jamz & z)) begin
            t = t | (32'd1 << (addr_w - 1));
        end
        if (jmpc) begin
            t = t | mbr;
        end
        return t;
    endfunction

endpackage

// File: rtl/mic1_ustack.sv
// Small LIFO holding microcode return addresses. Push into a full stack and pop from
// an empty stack are ignored; the sequencer flags those cases itself.
module mic1_ustack #(
    parameter int unsigned WIDTH = 9,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             full
);

    localparam int unsigned PW = $clog2(DEPTH + 1);
    localparam int unsigned IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [PW-1:0]    ptr;
    logic [PW-1:0]    top_ptr;
    logic [WIDTH-1:0] mem [DEPTH];

    assign top_ptr = ptr - 1'b1;
    assign empty   = (ptr == '0);
    assign full    = (ptr == PW'(DEPTH));
    assign dout    = empty ? '0 : mem[top_ptr[IW-1:0]];

    // Pointer update; push wins if both are asserted
    always_ff @(posedge clk) begin
        if (!rst) begin
            ptr <= '0;
        end else if (push && !full) begin
            ptr <= ptr + 1'b1;
        end else if (pop && !empty) begin
            ptr <= ptr - 1'b1;
        end
    end

    // Entry storage, written at the current pointer on push
    always_ff @(posedge clk) begin
        if (push && !full) begin
            mem[ptr[IW-1:0]] <= din;
        end
    end

endmodule

// File: rtl/mic1_microsequencer.sv
// Next-microinstruction-address unit for the MIC-1 control path. Computes the JAM/JMPC
// target, registers it into MPC, and honours stall. Define MICROSEQ_STACK_EN to add a
// microcode call/return stack; without it call/ret are ignored.
module mic1_microsequencer
    import mic1_pkg::*;
#(
    parameter int unsigned       ADDR_W      = MIC1_ADDR_W,
    parameter int unsigned       MBR_W       = MIC1_MBR_W,
    parameter int unsigned       STACK_DEPTH = 4,
    parameter logic [ADDR_W-1:0] RESET_ADDR  = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              N,
    input  logic              Z,
    input  logic [MBR_W-1:0]  MBR,
    input  logic [ADDR_W-1:0] next_addr,
    input  logic              jmpc,
    input  logic              jamn,
    input  logic              jamz,
    input  logic              call,
    input  logic              ret,
    output logic [ADDR_W-1:0] MPC,
    output logic              stk_empty,
    output logic              stk_full,
    output logic              stk_err
);

    logic [ADDR_W-1:0] target;

    assign target = ADDR_W'(mic1_next_addr(32'(next_addr), jmpc, jamn, jamz, N, Z,
                                           32'(MBR), ADDR_W));

`ifdef MICROSEQ_STACK_EN

    logic [1:0]        stk_op;
    logic              err_set;
    logic              err_q;
    logic [ADDR_W-1:0] mpc_d;
    logic [ADDR_W-1:0] mpc_inc;
    logic [ADDR_W-1:0] stk_top;

    assign mpc_inc = MPC + 1'b1;
    assign stk_err = err_q;

    // Select stack operation, next MPC and error condition; ret takes priority over call
    always_comb begin
        stk_op  = STK_NOP;
        err_set = 1'b0;
        mpc_d   = target;
        if (ret) begin
            err_set = call;
            if (stk_empty) begin
                mpc_d   = RESET_ADDR;
                err_set = 1'b1;
            end else begin
                mpc_d  = stk_top;
                stk_op = STK_POP;
            end
        end else if (call) begin
            if (stk_full) begin
                err_set = 1'b1;
            end else begin
                stk_op = STK_PUSH;
            end
        end
        if (stall) begin
            stk_op = STK_NOP;
        end
    end

    mic1_ustack #(
        .WIDTH (ADDR_W),
        .DEPTH (STACK_DEPTH)
    ) u_ustack (
        .clk   (clk),
        .rst   (rst),
        .push  (stk_op == STK_PUSH),
        .pop   (stk_op == STK_POP),
        .din   (mpc_inc),
        .dout  (stk_top),
        .empty (stk_empty),
        .full  (stk_full)
    );

    // MPC and sticky error register; both hold while stalled
    always_ff @(posedge clk) begin
        if (!rst) begin
            MPC   <= RESET_ADDR;
            err_q <= 1'b0;
        end else if (!stall) begin
            MPC   <= mpc_d;
            err_q <= err_q | err_set;
        end
    end

`else

    logic unused_stack_cfg;

    assign unused_stack_cfg = call ^ ret ^ (STACK_DEPTH == 0);
    assign stk_empty        = 1'b1;
    assign stk_full         = 1'b0;
    assign stk_err          = 1'b0;

    // MPC register: always follows the target unless stalled
    always_ff @(posedge clk) begin
        if (!rst) begin
            MPC <= RESET_ADDR;
        end else if (!stall) begin
            MPC <= target;
        end
    end

`endif

endmodule

// File: tb/tb_mic1_microsequencer.sv
// Directed bench for mic1_microsequencer. Stack scenarios run only when the build
// defines MICROSEQ_STACK_EN; otherwise call/ret are checked to be ignored.
module tb_mic1_microsequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       stall;
    logic       N;
    logic       Z;
    logic [7:0] MBR;
    logic [8:0] next_addr;
    logic       jmpc;
    logic       jamn;
    logic       jamz;
    logic       call;
    logic       ret;
    logic [8:0] MPC;
    logic       stk_empty;
    logic       stk_full;
    logic       stk_err;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mic1_microsequencer dut (
        .clk       (clk),
        .rst       (rst),
        .stall     (stall),
        .N         (N),
        .Z         (Z),
        .MBR       (MBR),
        .next_addr (next_addr),
        .jmpc      (jmpc),
        .jamn      (jamn),
        .jamz      (jamz),
        .call      (call),
        .ret       (ret),
        .MPC       (MPC),
        .stk_empty (stk_empty),
        .stk_full  (stk_full),
        .stk_err   (stk_err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mir();
        next_addr = '0;
        jmpc = 0; jamn = 0; jamz = 0; call = 0; ret = 0;
        N = 0; Z = 0; MBR = '0; stall = 0;
    endtask

    task automatic do_reset();
        rst = 0;
        step();
        rst = 1;
    endtask

    task automatic goto_addr(input logic [8:0] a);
        clear_mir();
        next_addr = a;
        step();
        clear_mir();
    endtask

    initial begin
        // Reset with every MIR bit asserted
        stall = 0; call = 1; ret = 1;
        next_addr = 9'h1FF; jmpc = 1; jamn = 1; jamz = 1;
        N = 1; Z = 1; MBR = 8'hFF;
        rst = 0;
        step();
        check("reset_mpc", 32'(MPC), 32'h000);
        check("reset_empty", 32'(stk_empty), 32'd1);
        check("reset_full", 32'(stk_full), 32'd0);
        check("reset_err", 32'(stk_err), 32'd0);
        rst = 1;
        clear_mir();

        // JAMZ / JAMN
        next_addr = 9'h012; jamz = 1; Z = 1;
        step(); check("jamz_taken", 32'(MPC), 32'h112);
        Z = 0;
        step(); check("jamz_not_taken", 32'(MPC), 32'h012);
        jamz = 0; jamn = 1; N = 1;
        step(); check("jamn_taken", 32'(MPC), 32'h112);
        N = 0;
        step(); check("jamn_not_taken", 32'(MPC), 32'h012);
        N = 1; Z = 1; jamz = 1; next_addr = 9'h1AB;
        step(); check("jam_bit_already_set", 32'(MPC), 32'h1AB);
        clear_mir();

        // JMPC
        next_addr = 9'h100; jmpc = 1; MBR = 8'h60;
        step(); check("jmpc_0x160", 32'(MPC), 32'h160);
        next_addr = 9'h000; MBR = 8'hFF;
        step(); check("jmpc_0x0ff", 32'(MPC), 32'h0FF);
        jmpc = 0; next_addr = 9'h044; MBR = 8'h3C;
        step(); check("jmpc_off", 32'(MPC), 32'h044);
        clear_mir();

        // Stall holds MPC, then releases
        goto_addr(9'h055);
        next_addr = 9'h0AA; stall = 1;
        for (int i = 0; i < 3; i++) begin
            step(); check("stall_hold", 32'(MPC), 32'h055);
        end
        stall = 0;
        step(); check("stall_release", 32'(MPC), 32'h0AA);

        // Reset overrides stall
        stall = 1; rst = 0;
        step(); check("reset_over_stall", 32'(MPC), 32'h000);
        rst = 1;
        clear_mir();

`ifdef MICROSEQ_STACK_EN
        // Call / return
        goto_addr(9'h020);
        call = 1; next_addr = 9'h080;
        step();
        check("call_target", 32'(MPC), 32'h080);
        check("call_not_empty", 32'(stk_empty), 32'd0);
        call = 0; ret = 1; next_addr = 9'h1FF;
        step();
        check("ret_addr", 32'(MPC), 32'h021);
        check("ret_empty", 32'(stk_empty), 32'd1);
        check("ret_no_err", 32'(stk_err), 32'd0);
        clear_mir();

        // Stalled call does not push
        call = 1; stall = 1; next_addr = 9'h0C0;
        step();
        check("stall_call_empty", 32'(stk_empty), 32'd1);
        check("stall_call_mpc", 32'(MPC), 32'h021);
        clear_mir();

        // Overflow and underflow
        do_reset();
        clear_mir();
        for (int i = 1; i <= 5; i++) begin
            call = 1; next_addr = 9'(i * 16);
            step();
            check("nest_call_mpc", 32'(MPC), 32'(i * 16));
            check("nest_full", 32'(stk_full), (i >= 4) ? 32'd1 : 32'd0);
            check("nest_err", 32'(stk_err), (i == 5) ? 32'd1 : 32'd0);
        end
        call = 0; ret = 1; next_addr = 9'h1EE;
        step(); check("pop1", 32'(MPC), 32'h031);
        check("pop1_not_full", 32'(stk_full), 32'd0);
        step(); check("pop2", 32'(MPC), 32'h021);
        step(); check("pop3", 32'(MPC), 32'h011);
        step(); check("pop4", 32'(MPC), 32'h001);
        check("pop4_empty", 32'(stk_empty), 32'd1);
        goto_addr(9'h077);
        ret = 1; next_addr = 9'h1EE;
        step();
        check("underflow_mpc", 32'(MPC), 32'h000);
        check("underflow_err", 32'(stk_err), 32'd1);
        clear_mir();
        step();
        check("err_sticky", 32'(stk_err), 32'd1);

        // Return address wraps from the top of the address space
        do_reset();
        goto_addr(9'h1FF);
        call = 1; next_addr = 9'h005;
        step(); check("wrap_call", 32'(MPC), 32'h005);
        call = 0; ret = 1;
        step();
        check("wrap_ret", 32'(MPC), 32'h000);
        check("wrap_no_err", 32'(stk_err), 32'd0);
        clear_mir();

        // call & ret together on an empty stack
        do_reset();
        call = 1; ret = 1; next_addr = 9'h077;
        step();
        check("callret_empty_mpc", 32'(MPC), 32'h000);
        check("callret_empty_err", 32'(stk_err), 32'd1);
        clear_mir();

        // call & ret together with one entry: pop only
        do_reset();
        call = 1; next_addr = 9'h030;
        step();
        call = 1; ret = 1; next_addr = 9'h090;
        step();
        check("callret_pop_mpc", 32'(MPC), 32'h001);
        check("callret_pop_empty", 32'(stk_empty), 32'd1);
        check("callret_pop_err", 32'(stk_err), 32'd1);
        clear_mir();
`else
        // Without the stack, call and ret are ignored
        call = 1; next_addr = 9'h080;
        step();
        check("nostk_call_mpc", 32'(MPC), 32'h080);
        check("nostk_call_empty", 32'(stk_empty), 32'd1);
        call = 0; ret = 1; next_addr = 9'h033;
        step();
        check("nostk_ret_mpc", 32'(MPC), 32'h033);
        check("nostk_ret_err", 32'(stk_err), 32'd0);
        check("nostk_ret_empty", 32'(stk_empty), 32'd1);
        check("nostk_ret_full", 32'(stk_full), 32'd0);
        call = 1; ret = 1; next_addr = 9'h012; jamz = 1; Z = 1;
        step();
        check("nostk_callret_mpc", 32'(MPC), 32'h112);
        check("nostk_callret_err", 32'(stk_err), 32'd0);
        clear_mir();
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
